// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: icodes, register specifiers and processor status.
// Pure definitions; no timing or flow control involved.
package y86_pkg;

    localparam logic [3:0] I_HALT  = 4'h0;
    localparam logic [3:0] I_NOP   = 4'h1;
    localparam logic [3:0] I_CMOV  = 4'h2;
    localparam logic [3:0] I_IRMOV = 4'h3;
    localparam logic [3:0] I_RMMOV = 4'h4;
    localparam logic [3:0] I_MRMOV = 4'h5;
    localparam logic [3:0] I_OPQ   = 4'h6;
    localparam logic [3:0] I_JXX   = 4'h7;
    localparam logic [3:0] I_CALL  = 4'h8;
    localparam logic [3:0] I_RET   = 4'h9;
    localparam logic [3:0] I_PUSH  = 4'hA;
    localparam logic [3:0] I_POP   = 4'hB;

    localparam logic [3:0] R_RSP  = 4'h4;
    localparam logic [3:0] R_NONE = 4'hF;

    typedef enum logic [1:0] {
        STAT_AOK = 2'd0,
        STAT_HLT = 2'd1,
        STAT_INS = 2'd2
    } stat_e;

    function automatic logic icode_legal(input logic [3:0] ic);
        return ic <= I_POP;
    endfunction

endpackage

// File: rtl/reg_file_15x64.sv
// 15x64 register file: two combinational read ports (F reads 0), two write ports.
// Writes land on the clock edge; M port wins when both target the same register.
module reg_file_15x64
    import y86_pkg::*;
#(
    parameter logic [63:0] RST_RSP = 64'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  src_a_i,
    input  logic [3:0]  src_b_i,
    output logic [63:0] rd_a_o,
    output logic [63:0] rd_b_o,
    input  logic        we_e_i,
    input  logic [3:0]  dst_e_i,
    input  logic [63:0] val_e_i,
    input  logic        we_m_i,
    input  logic [3:0]  dst_m_i,
    input  logic [63:0] val_m_i
);

    logic [63:0] regs_q [15];
    logic [63:0] regs_d [15];

    // E applied first so a colliding M write overrides it.
    always_comb begin
        regs_d = regs_q;
        if (we_e_i && dst_e_i != R_NONE) regs_d[dst_e_i] = val_e_i;
        if (we_m_i && dst_m_i != R_NONE) regs_d[dst_m_i] = val_m_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 15; i++) begin
                regs_q[i] <= (i == int'(R_RSP)) ? RST_RSP : 64'h0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    assign rd_a_o = (src_a_i == R_NONE) ? 64'h0 : regs_q[src_a_i];
    assign rd_b_o = (src_b_i == R_NONE) ? 64'h0 : regs_q[src_b_i];

endmodule

// File: rtl/decode_writeback.sv
// Decode operand select + writeback commit around the register file, with run/halt/invalid status.
// Decode is combinational; writeback and status land on the wb_en edge; no backpressure.
module decode_writeback
    import y86_pkg::*;
#(
    parameter logic [63:0] RST_RSP = 64'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_en,
    input  logic [3:0]  icode,
    input  logic [3:0]  rA,
    input  logic [3:0]  rB,
    input  logic        cnd,
    input  logic [63:0] valE,
    input  logic [63:0] valM,
    input  logic        imem_err,
    output logic [63:0] valA,
    output logic [63:0] valB,
    output logic [3:0]  dstE,
    output logic [3:0]  dstM,
    output logic [1:0]  stat
);

    stat_e      stat_q;
    logic [3:0] src_a;
    logic [3:0] src_b;
    logic       instr_ok;
    logic       commit;

    always_comb begin
        src_a = R_NONE;
        case (icode)
            I_CMOV, I_RMMOV, I_OPQ, I_PUSH: src_a = rA;
            I_RET, I_POP:                   src_a = R_RSP;
            default:                        src_a = R_NONE;
        endcase
    end

    always_comb begin
        src_b = R_NONE;
        case (icode)
            I_RMMOV, I_MRMOV, I_OPQ:      src_b = rB;
            I_CALL, I_RET, I_PUSH, I_POP: src_b = R_RSP;
            default:                      src_b = R_NONE;
        endcase
    end

    always_comb begin
        dstE = R_NONE;
        case (icode)
            I_IRMOV, I_OPQ:               dstE = rB;
            I_CMOV:                       dstE = cnd ? rB : R_NONE;
            I_CALL, I_RET, I_PUSH, I_POP: dstE = R_RSP;
            default:                      dstE = R_NONE;
        endcase
    end

    always_comb begin
        dstM = R_NONE;
        case (icode)
            I_MRMOV, I_POP: dstM = rA;
            default:        dstM = R_NONE;
        endcase
    end

    assign instr_ok = icode_legal(icode) && !imem_err;
    // halt has no destinations, so it needs no special case here
    assign commit   = wb_en && (stat_q == STAT_AOK) && instr_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_q <= STAT_AOK;
        end else if (wb_en && stat_q == STAT_AOK) begin
            if (!instr_ok) begin
                stat_q <= STAT_INS;
            end else if (icode == I_HALT) begin
                stat_q <= STAT_HLT;
            end
        end
    end

    assign stat = stat_q;

    reg_file_15x64 #(
        .RST_RSP (RST_RSP)
    ) u_rf (
        .clk     (clk),
        .rst     (rst),
        .src_a_i (src_a),
        .src_b_i (src_b),
        .rd_a_o  (valA),
        .rd_b_o  (valB),
        .we_e_i  (commit),
        .dst_e_i (dstE),
        .val_e_i (valE),
        .we_m_i  (commit),
        .dst_m_i (dstM),
        .val_m_i (valM)
    );

endmodule

// File: tb/tb_decode_writeback.sv
// Scoreboarded bench for decode_writeback: expected register values queued at write time.
module tb_decode_writeback;

    localparam logic [63:0] RST_VAL = 64'h100;
    localparam logic [3:0]  NONE    = 4'hF;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wb_en = 1'b0;
    logic [3:0]  icode = 4'h1;
    logic [3:0]  rA = 4'hF;
    logic [3:0]  rB = 4'hF;
    logic        cnd = 1'b0;
    logic [63:0] valE = '0;
    logic [63:0] valM = '0;
    logic        imem_err = 1'b0;
    logic [63:0] valA, valB;
    logic [3:0]  dstE, dstM;
    logic [1:0]  stat;

    int          errors = 0;
    int          checks = 0;
    logic [63:0] exp_q [$];
    logic [63:0] model [15];
    logic [63:0] exp_v;

    decode_writeback #(.RST_RSP(RST_VAL)) dut (
        .clk(clk), .rst(rst), .wb_en(wb_en), .icode(icode), .rA(rA), .rB(rB),
        .cnd(cnd), .valE(valE), .valM(valM), .imem_err(imem_err),
        .valA(valA), .valB(valB), .dstE(dstE), .dstM(dstM), .stat(stat)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic [3:0] ic, input logic [3:0] a, input logic [3:0] b,
                         input logic c, input logic [63:0] e, input logic [63:0] m,
                         input logic w, input logic err);
        @(negedge clk);
        icode = ic; rA = a; rB = b; cnd = c; valE = e; valM = m; wb_en = w; imem_err = err;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        wb_en = 1'b0;
    endtask

    // Non-committing OPq so both read ports show register r.
    task automatic drive_read(input int r);
        drive(4'h6, 4'(r), 4'(r), 1'b0, 64'h0, 64'h0, 1'b0, 1'b0);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 15; i++) model[i] = 64'h0;
        model[4] = RST_VAL;
    endtask

    task automatic do_reset();
        drive(4'h1, NONE, NONE, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_reset();
    endtask

    task automatic pop_check_reg(input int r, input string name);
        drive_read(r);
        if (exp_q.size() == 0) begin
            $display("FAIL %s: scoreboard empty", name);
            errors++;
        end else begin
            exp_v = exp_q.pop_front();
            if (valB !== exp_v || valA !== exp_v) begin
                $display("FAIL %s: r%0d valA=%h valB=%h expected %h", name, r, valA, valB, exp_v);
                errors++;
            end
        end
        checks++;
    endtask

    task automatic test_reset();
        do_reset();
        if (stat !== 2'd0) begin $display("FAIL reset_stat: got %0d expected 0", stat); errors++; end
        checks++;
        drive(4'hA, NONE, NONE, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0);
        if (valB !== RST_VAL) begin $display("FAIL reset_rsp: got %h expected %h", valB, RST_VAL); errors++; end
        checks++;
        if (valA !== 64'h0) begin $display("FAIL reset_srcF: got %h expected 0", valA); errors++; end
        checks++;
        for (int r = 0; r < 15; r++) begin
            exp_q.push_back(model[r]);
            pop_check_reg(r, "reset_reg");
        end
    endtask

    task automatic test_read_before_write();
        drive(4'h6, 4'd2, 4'd2, 1'b0, 64'h5, 64'h0, 1'b1, 1'b0);
        model[2] = 64'h5;
        exp_q.push_back(64'h5);
        if (valB !== 64'h0) begin $display("FAIL rbw_same_cycle: got %h expected 0", valB); errors++; end
        checks++;
        if (dstE !== 4'd2) begin $display("FAIL rbw_dstE: got %h expected 2", dstE); errors++; end
        checks++;
        step();
        pop_check_reg(2, "rbw_next_cycle");
        drive(4'h3, NONE, 4'd5, 1'b0, 64'h5A5A, 64'h0, 1'b1, 1'b0);
        model[5] = 64'h5A5A;
        exp_q.push_back(64'h5A5A);
        step();
        pop_check_reg(5, "irmov_r5");
    endtask

    task automatic test_cmov();
        drive(4'h2, 4'd2, 4'd3, 1'b0, 64'h7, 64'h0, 1'b1, 1'b0);
        if (dstE !== NONE) begin $display("FAIL cmov_nc_dstE: got %h expected f", dstE); errors++; end
        checks++;
        if (valA !== model[2]) begin $display("FAIL cmov_valA: got %h expected %h", valA, model[2]); errors++; end
        checks++;
        exp_q.push_back(model[3]);
        step();
        pop_check_reg(3, "cmov_not_taken");
        drive(4'h2, 4'd2, 4'd3, 1'b1, 64'h7, 64'h0, 1'b1, 1'b0);
        if (dstE !== 4'd3) begin $display("FAIL cmov_t_dstE: got %h expected 3", dstE); errors++; end
        checks++;
        model[3] = 64'h7;
        exp_q.push_back(64'h7);
        step();
        pop_check_reg(3, "cmov_taken");
    endtask

    task automatic test_stack();
        drive(4'hA, 4'd2, NONE, 1'b0, 64'h50, 64'h0, 1'b1, 1'b0);
        if (valA !== model[2] || valB !== model[4]) begin
            $display("FAIL push_operands: got %h/%h expected %h/%h", valA, valB, model[2], model[4]); errors++;
        end
        checks++;
        model[4] = 64'h50;
        exp_q.push_back(64'h50);
        step();
        pop_check_reg(4, "push_rsp");
        drive(4'hB, 4'd4, NONE, 1'b0, 64'h108, 64'hAB, 1'b1, 1'b0);
        if (dstE !== 4'd4 || dstM !== 4'd4) begin
            $display("FAIL pop_dst: got %h/%h expected 4/4", dstE, dstM); errors++;
        end
        checks++;
        model[4] = 64'hAB;
        exp_q.push_back(64'hAB);
        step();
        pop_check_reg(4, "popq_rsp_m_wins");
        drive(4'h5, 4'd6, NONE, 1'b0, 64'hDEAD, 64'h1234, 1'b1, 1'b0);
        if (dstM !== 4'd6 || dstE !== NONE) begin
            $display("FAIL mrmov_dst: got E=%h M=%h expected f/6", dstE, dstM); errors++;
        end
        checks++;
        model[6] = 64'h1234;
        exp_q.push_back(64'h1234);
        step();
        pop_check_reg(6, "mrmov_r6");
    endtask

    task automatic test_back_to_back();
        logic [63:0] v;
        for (int i = 0; i < 8; i++) begin
            v = {$urandom, $urandom};
            drive(4'h3, NONE, 4'(i + 7), 1'b0, v, 64'h0, 1'b1, 1'b0);
            model[i + 7] = v;
            exp_q.push_back(v);
            @(posedge clk);
        end
        #1 wb_en = 1'b0;
        for (int i = 0; i < 8; i++) pop_check_reg(i + 7, "b2b_readback");
    endtask

    task automatic test_no_wb();
        drive(4'h3, NONE, 4'd7, 1'b0, 64'hBEEF, 64'h0, 1'b0, 1'b0);
        exp_q.push_back(model[7]);
        step();
        pop_check_reg(7, "nowb_reg");
        drive(4'h0, NONE, NONE, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0);
        step();
        if (stat !== 2'd0) begin $display("FAIL nowb_stat: got %0d expected 0", stat); errors++; end
        checks++;
    endtask

    task automatic test_halt();
        drive(4'h0, NONE, NONE, 1'b0, 64'h0, 64'h0, 1'b1, 1'b0);
        if (stat !== 2'd0) begin $display("FAIL halt_pre_stat: got %0d expected 0", stat); errors++; end
        checks++;
        step();
        drive(4'h3, NONE, 4'd1, 1'b0, 64'h9, 64'h0, 1'b1, 1'b0);
        if (stat !== 2'd1) begin $display("FAIL halt_stat: got %0d expected 1", stat); errors++; end
        checks++;
        exp_q.push_back(model[1]);
        step();
        pop_check_reg(1, "halt_suppress");
        exp_q.push_back(model[2]);
        pop_check_reg(2, "halt_read_tracks");
        do_reset();
        if (stat !== 2'd0) begin $display("FAIL halt_rst_stat: got %0d expected 0", stat); errors++; end
        checks++;
    endtask

    task automatic test_invalid();
        drive(4'h3, NONE, 4'd1, 1'b0, 64'h9, 64'h0, 1'b1, 1'b1);
        exp_q.push_back(model[1]);
        step();
        if (stat !== 2'd2) begin $display("FAIL imem_err_stat: got %0d expected 2", stat); errors++; end
        checks++;
        pop_check_reg(1, "imem_err_nowrite");
        do_reset();
        drive(4'hC, 4'd3, 4'd3, 1'b1, 64'h77, 64'h66, 1'b1, 1'b0);
        step();
        if (stat !== 2'd2) begin $display("FAIL icodeC_stat: got %0d expected 2", stat); errors++; end
        checks++;
        drive(4'h3, NONE, 4'd3, 1'b0, 64'h33, 64'h0, 1'b1, 1'b0);
        exp_q.push_back(model[3]);
        step();
        pop_check_reg(3, "ins_suppress");
        do_reset();
    endtask

    task automatic test_rst_over_wb();
        drive(4'h3, NONE, 4'd1, 1'b0, 64'h55, 64'h0, 1'b1, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_reset();
        exp_q.push_back(model[1]);
        pop_check_reg(1, "rst_drops_write");
        drive(4'h3, NONE, 4'd1, 1'b0, 64'h77, 64'h0, 1'b1, 1'b0);
        model[1] = 64'h77;
        exp_q.push_back(64'h77);
        step();
        pop_check_reg(1, "post_rst_write");
    endtask

    initial begin
        test_reset();
        test_read_before_write();
        test_cmov();
        test_stack();
        test_back_to_back();
        test_no_wb();
        test_halt();
        test_invalid();
        test_rst_over_wb();
        if (exp_q.size() != 0) begin
            $display("FAIL scoreboard_leftover: got %0d entries expected 0", exp_q.size());
            errors++;
        end
        checks++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
